// File: rtl/spi_shader_loader.sv
// SPI mode-1 host that streams a NUM_BYTES burst from a valid/ready byte stream to the shader
// receiver, capturing MISO in parallel for read-back.
module spi_shader_loader #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned NUM_BYTES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_cs_o
);

    localparam int unsigned     CntW     = $clog2(NUM_BYTES + 1);
    localparam logic [7:0]      DivLast  = 8'(CLK_DIV - 1);
    localparam logic [CntW-1:0] ByteLast = CntW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StLoad, StShift, StHold, StGap} state_e;

    state_e          state_q, state_d;
    logic [7:0]      div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rx_valid_q, rx_valid_d;
    logic            div_end;

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_byte_d  = rx_byte_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        rx_valid_d = 1'b0;
        div_end    = (div_q == DivLast);
        div_d      = div_end ? 8'd0 : div_q + 8'd1;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSetup;
                    cs_d    = 1'b0;
                end
            end
            StSetup: begin
                if (div_end) begin
                    state_d = StLoad;
                    ready_d = 1'b1;
                end
            end
            StLoad: begin
                if (byte_valid_i && ready_q) begin
                    state_d = StShift;
                    ready_d = 1'b0;
                    sclk_d  = 1'b1;
                    mosi_d  = byte_i[7];
                    tx_d    = {byte_i[6:0], 1'b0};
                    bit_d   = 3'd0;
                end
            end
            StShift: begin
                // sclk_q doubles as the phase flag: high phase ends in a fall, low phase in a rise
                if (div_end) begin
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        rx_sh_d = {rx_sh_q[6:0], spi_miso_i};
                    end else if (bit_q != 3'd7) begin
                        sclk_d = 1'b1;
                        mosi_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                        bit_d  = bit_q + 3'd1;
                    end else begin
                        rx_byte_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        cnt_d      = cnt_q + CntW'(1);
                        if (cnt_q == ByteLast) begin
                            state_d = StHold;
                        end else begin
                            state_d = StLoad;
                            ready_d = 1'b1;
                        end
                    end
                end
            end
            StHold: begin
                if (div_end) begin
                    state_d = StGap;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            StGap: begin
                if (div_end) begin
                    state_d = StIdle;
                    mosi_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            div_d = 8'd0;
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            div_q      <= 8'd0;
            bit_q      <= 3'd0;
            cnt_q      <= '0;
            tx_q       <= 8'd0;
            rx_sh_q    <= 8'd0;
            rx_byte_q  <= 8'd0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_byte_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign rx_byte_o    = rx_byte_q;
    assign rx_valid_o   = rx_valid_q;
    assign spi_sclk_o   = sclk_q;
    assign spi_mosi_o   = mosi_q;
    assign spi_cs_o     = cs_q;

endmodule

// File: tb/tb_spi_shader_loader.sv
// Bench for spi_shader_loader: mode-1 receiver/slave models, stream feeder with a stall, and a
// second tiny instance (CLK_DIV=1, NUM_BYTES=1) with MOSI looped back to MISO.
module tb_spi_shader_loader;

    localparam int StallAt  = 21;
    localparam int StallLen = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bbyte = 8'd0;
    logic       bvalid = 1'b0;
    logic       bready, busy, done, rxv, sclk, mosi, cs;
    logic       miso = 1'b0;
    logic [7:0] rxb;

    logic       b_start = 1'b0;
    logic [7:0] b_byte = 8'd0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_busy, b_done, b_rxv, b_sclk, b_mosi, b_cs;
    logic [7:0] b_rx;

    spi_shader_loader #(.CLK_DIV(2), .NUM_BYTES(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .byte_i(bbyte), .byte_valid_i(bvalid),
        .byte_ready_o(bready), .busy_o(busy), .done_o(done), .rx_byte_o(rxb), .rx_valid_o(rxv),
        .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso), .spi_cs_o(cs)
    );

    spi_shader_loader #(.CLK_DIV(1), .NUM_BYTES(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .byte_i(b_byte), .byte_valid_i(b_valid),
        .byte_ready_o(b_ready), .busy_o(b_busy), .done_o(b_done), .rx_byte_o(b_rx),
        .rx_valid_o(b_rxv), .spi_sclk_o(b_sclk), .spi_mosi_o(b_mosi), .spi_miso_i(b_mosi),
        .spi_cs_o(b_cs)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] src[64];
    logic [7:0] miso_src[64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Mode-1 receiver model for the main instance: samples MOSI on SCLK falls, resyncs on CS high
    int         a_rises = 0, a_cs_low = 0, a_done_cnt = 0, a_rxv_cnt = 0, a_dec_n = 0;
    logic [7:0] a_dec[128];
    logic [7:0] rx_log[128];
    initial begin
        logic       prev = 1'b0;
        int         rbits = 0;
        logic [7:0] rsh = 8'd0;
        forever begin
            @(negedge clk);
            if (!cs) a_cs_low++;
            if (done) a_done_cnt++;
            if (rxv && a_rxv_cnt < 128) begin
                rx_log[a_rxv_cnt] = rxb;
                a_rxv_cnt++;
            end
            if (cs) begin
                rbits = 0;
            end else if (sclk && !prev) begin
                a_rises++;
            end else if (!sclk && prev) begin
                rsh = {rsh[6:0], mosi};
                rbits++;
                if (rbits == 8) begin
                    if (a_dec_n < 128) a_dec[a_dec_n] = rsh;
                    a_dec_n++;
                    rbits = 0;
                end
            end
            prev = sclk;
        end
    end

    // Mode-1 slave model: presents the next MISO bit on each SCLK rise
    initial begin
        logic       prev = 1'b0;
        int         s_bit = 0, s_idx = 0;
        logic [7:0] cur;
        forever begin
            @(negedge clk);
            if (cs) begin
                if (s_bit != 0) begin
                    s_idx++;
                    s_bit = 0;
                end
            end else if (sclk && !prev) begin
                cur = miso_src[s_idx % 64];
                miso = cur[7 - s_bit];
                s_bit++;
                if (s_bit == 8) begin
                    s_bit = 0;
                    s_idx++;
                end
            end
            prev = sclk;
        end
    end

    // Byte feeder: always offers the next byte, except StallLen LOAD cycles before byte StallAt
    int f_idx = 0, stall_cnt = 0, bad_stall = 0;
    initial begin
        bit hs_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (hs_pend) f_idx++;
            if (f_idx == StallAt && stall_cnt < StallLen) begin
                bvalid = 1'b0;
                if (bready) begin
                    stall_cnt++;
                    if (sclk || cs) bad_stall++;
                end
            end else if (f_idx < 64) begin
                bvalid = 1'b1;
                bbyte  = src[f_idx];
            end else begin
                bvalid = 1'b0;
            end
            hs_pend = bvalid && bready;
        end
    end

    // Second instance observer: MOSI and timestamp at every SCLK rise
    int   b_rises = 0, b_cs_low = 0, b_done_cnt = 0, b_t = 0;
    logic b_rise_mosi[16];
    int   b_rise_t[16];
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            b_t++;
            if (!b_cs) b_cs_low++;
            if (b_done) b_done_cnt++;
            if (!b_cs && b_sclk && !prev && b_rises < 16) begin
                b_rise_mosi[b_rises] = b_mosi;
                b_rise_t[b_rises]    = b_t;
                b_rises++;
            end
            prev = b_sclk;
        end
    end

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n = 0;
        while (a_done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(a_done_cnt != d0), 32'd1);
    endtask

    task automatic check_burst(input string tag, input int c0, input int exp_low, input int r0,
                               input int d0, input int s0, input int v0, input int m0,
                               input int nbytes);
        check({tag, "_cs_low"}, a_cs_low - c0, exp_low);
        check({tag, "_rises"}, a_rises - r0, nbytes * 8);
        check({tag, "_ndec"}, a_dec_n - d0, nbytes);
        check({tag, "_nrx"}, a_rxv_cnt - v0, nbytes);
        for (int k = 0; k < nbytes; k++) begin
            check($sformatf("%s_dec%0d", tag, k), a_dec[d0 + k], src[s0 + k]);
            check($sformatf("%s_rx%0d", tag, k), rx_log[v0 + k], miso_src[m0 + k]);
        end
    endtask

    initial begin
        int c0, r0, d0, v0, dn0, n;
        logic [7:0] b_exp;

        for (int i = 0; i < 64; i++) begin
            src[i]      = (i < 16) ? 8'(i) : 8'($urandom_range(0, 255));
            miso_src[i] = 8'($urandom_range(0, 255));
        end
        miso_src[0] = 8'hA5;
        miso_src[1] = 8'h3C;

        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", bready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rxbyte", rxb, 0);
        check("rst_rxvalid", rxv, 0);
        check("rst_b_cs", b_cs, 1);
        rst_n = 1'b1;
        tick();

        // Burst 1: bytes 0x00..0x0F, no stalls, MISO 0xA5, 0x3C, ...
        c0 = a_cs_low; r0 = a_rises; d0 = a_dec_n; v0 = a_rxv_cnt; dn0 = a_done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b1_busy", busy, 1);
        check("b1_cs_low", cs, 0);
        wait_done(dn0, 2000, "b1_done_seen");
        repeat (4) tick();
        check_burst("b1", c0, 532, r0, d0, 0, v0, 0, 16);
        check("b1_done_once", a_done_cnt - dn0, 1);
        check("b1_mosi_idle", mosi, 0);
        check("b1_busy_end", busy, 0);

        // Burst 2: random bytes, 20-cycle stall before byte 5, start held high into GAP
        c0 = a_cs_low; r0 = a_rises; d0 = a_dec_n; v0 = a_rxv_cnt; dn0 = a_done_cnt;
        start = 1'b1;
        wait_done(dn0, 3000, "b2_done_seen");
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_burst("b2", c0, 552, r0, d0, 16, v0, 16, 16);
        check("b2_stall_len", stall_cnt, StallLen);
        check("b2_stall_frozen", bad_stall, 0);
        check("b2_done_once", a_done_cnt - dn0, 1);
        c0 = a_cs_low;
        repeat (10) tick();
        check("b2_no_rerun", a_cs_low - c0, 0);
        check("b2_idle_busy", busy, 0);
        check("b2_idle_cs", cs, 1);

        // Burst 3: reset in the high phase of bit 3 of byte 7
        c0 = a_cs_low; r0 = a_rises; d0 = a_dec_n; v0 = a_rxv_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (a_rises - r0 != 60 && n < 3000) begin
            tick();
            n++;
        end
        check("b3_reset_point", 32'(a_rises - r0 == 60), 32'd1);
        check("b3_sclk_high", sclk, 1);
        rst_n = 1'b0;
        #1;
        check("b3_rst_cs", cs, 1);
        check("b3_rst_sclk", sclk, 0);
        check("b3_rst_busy", busy, 0);
        check("b3_rst_rxbyte", rxb, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("b3_ndec", a_dec_n - d0, 7);
        check("b3_nrx", a_rxv_cnt - v0, 7);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("b3_dec%0d", k), a_dec[d0 + k], src[32 + k]);
        end

        // Burst 4: full fresh burst after reset
        c0 = a_cs_low; r0 = a_rises; d0 = a_dec_n; v0 = a_rxv_cnt; dn0 = a_done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(dn0, 2000, "b4_done_seen");
        repeat (4) tick();
        check_burst("b4", c0, 532, r0, d0, 40, v0, 40, 16);

        // Second instance: CLK_DIV=1, NUM_BYTES=1, byte 0x81, loopback MISO
        b_exp   = 8'h81;
        b_byte  = b_exp;
        b_valid = 1'b1;
        c0 = b_cs_low;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        repeat (40) tick();
        check("sb_rises", b_rises, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("sb_mosi%0d", k), b_rise_mosi[k], b_exp[7 - k]);
        end
        check("sb_period", b_rise_t[1] - b_rise_t[0], 2);
        check("sb_span", b_rise_t[7] - b_rise_t[0], 14);
        check("sb_cs_low", b_cs_low - c0, 19);
        check("sb_rx", b_rx, b_exp);
        check("sb_done_once", b_done_cnt, 1);
        check("sb_busy_end", b_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
